// File: rtl/referee_wrr.sv
// Weighted round-robin referee: pops one source FIFO per grant, forwards the word to the destination named in its dest field.
// Latency: pop registered on the grant edge; push two cycles after the pop; back-to-back transfers start every 3 cycles.
// Backpressure: any almost-full destination or disabled enable holds off new grants; an in-flight transfer always completes.
module referee_wrr #(
    parameter int NUM_CH      = 4,
    parameter int NUM_DEST    = 4,
    parameter int LINE_SIZE   = 12,
    parameter int CLASS_BITS  = 2,
    parameter int DEST_BITS   = 2,
    parameter int WEIGHT_BITS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             almost_empty_signal,
    input  logic [NUM_DEST-1:0]           almost_full_signal,
    input  logic [LINE_SIZE-1:0]          data_in,
    input  logic [NUM_CH*WEIGHT_BITS-1:0] weight_cfg,
    input  logic                          enable,
    output logic [NUM_CH-1:0]             pop_signal,
    output logic [NUM_DEST-1:0]           push_signal,
    output logic [LINE_SIZE-1:0]          data_out,
    output logic                          dest_err,
    output logic [15:0]                   tx_count,
    output logic                          idle
);

    localparam int PTR_W  = $clog2(NUM_CH);
    localparam int USED_W = WEIGHT_BITS + 1;

    typedef enum logic [1:0] {ARB, POP, LATCH, PUSH} state_t;

    state_t              state;
    logic [PTR_W-1:0]    ptr;
    logic [USED_W-1:0]   used;

    logic [NUM_CH-1:0]   eligible;
    logic                any_eligible;
    logic [PTR_W-1:0]    grant_ch;
    logic [USED_W-1:0]   grant_used;
    logic [PTR_W-1:0]    cand;
    logic                found;
    logic [PTR_W-1:0]    next_ptr;
    logic [USED_W-1:0]   next_used;
    logic [NUM_CH-1:0]   pop_onehot;

    logic [DEST_BITS-1:0] word_dest;
    logic                 dest_ok;
    logic [NUM_DEST-1:0]  push_onehot;

    // Grant quota of a channel is its weight field plus one (1..2^WEIGHT_BITS).
    function automatic logic [USED_W-1:0] quota_of(input logic [NUM_CH*WEIGHT_BITS-1:0] w,
                                                   input logic [PTR_W-1:0] ch);
        return {1'b0, w[int'(ch)*WEIGHT_BITS +: WEIGHT_BITS]} + USED_W'(1);
    endfunction

    assign eligible     = (enable && !(|almost_full_signal)) ? ~almost_empty_signal : '0;
    assign any_eligible = |eligible;

    // Pick the next grant: stay on ptr while its quota lasts, else first eligible channel after ptr.
    always_comb begin
        grant_ch   = ptr;
        grant_used = used + USED_W'(1);
        found      = 1'b0;
        cand       = '0;
        if (!(eligible[ptr] && (used < quota_of(weight_cfg, ptr)))) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                cand = PTR_W'((int'(ptr) + k) % NUM_CH);
                if (!found && eligible[cand]) begin
                    found      = 1'b1;
                    grant_ch   = cand;
                    grant_used = USED_W'(1);
                end
            end
        end
        // Quota exhausted by this grant: move on to the following channel with a fresh count.
        if (grant_used == quota_of(weight_cfg, grant_ch)) begin
            next_ptr  = PTR_W'((int'(grant_ch) + 1) % NUM_CH);
            next_used = '0;
        end else begin
            next_ptr  = grant_ch;
            next_used = grant_used;
        end
        pop_onehot           = '0;
        pop_onehot[grant_ch] = 1'b1;
    end

    assign word_dest = data_in[LINE_SIZE-CLASS_BITS-1 -: DEST_BITS];
    assign dest_ok   = int'(word_dest) < NUM_DEST;

    // Decode the destination of the incoming word into a one-hot push; out-of-range dest pushes nowhere.
    always_comb begin
        push_onehot = '0;
        for (int d = 0; d < NUM_DEST; d++) begin
            if (dest_ok && (word_dest == DEST_BITS'(d))) begin
                push_onehot[d] = 1'b1;
            end
        end
    end

    // Transfer FSM; the PUSH cycle also arbitrates so a new pop can follow immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB;
            ptr         <= '0;
            used        <= '0;
            pop_signal  <= '0;
            push_signal <= '0;
            data_out    <= '0;
            dest_err    <= 1'b0;
            tx_count    <= '0;
        end else begin
            case (state)
                ARB, PUSH: begin
                    push_signal <= '0;
                    dest_err    <= 1'b0;
                    if (any_eligible) begin
                        pop_signal <= pop_onehot;
                        ptr        <= next_ptr;
                        used       <= next_used;
                        state      <= POP;
                    end else begin
                        pop_signal <= '0;
                        state      <= ARB;
                    end
                end
                POP: begin
                    pop_signal <= '0;
                    state      <= LATCH;
                end
                LATCH: begin
                    data_out    <= data_in;
                    push_signal <= push_onehot;
                    dest_err    <= !dest_ok;
                    if (dest_ok) begin
                        tx_count <= tx_count + 16'd1;
                    end
                    state <= PUSH;
                end
                default: begin
                    state <= ARB;
                end
            endcase
        end
    end

    assign idle = (state == ARB) && !(|pop_signal);

endmodule

// File: doc/referee_wrr.md
REFEREE_WRR -- requirements
Module: referee_wrr

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of source (pop) FIFOs, 2..16.
REQ-002 SHALL have parameter NUM_DEST, default 4: number of destination (push) FIFOs, 2..16.
REQ-003 SHALL have parameter LINE_SIZE, default 12: word width; word is class[MSBs], dest, payload.
REQ-004 SHALL have parameter CLASS_BITS, default 2: class field width at word MSBs.
REQ-005 SHALL have parameter DEST_BITS, default 2: dest field, bits [LINE_SIZE-CLASS_BITS-1 -: DEST_BITS].
REQ-006 SHALL have parameter WEIGHT_BITS, default 2: per-channel weight field width.
REQ-007 clk  input  1  single clock; all state updates on posedge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 almost_empty_signal  input  NUM_CH  per-source FIFO almost-empty.
REQ-010 almost_full_signal  input  NUM_DEST  per-destination FIFO almost-full.
REQ-011 data_in  input  LINE_SIZE  shared read data; valid the cycle after the pop.
REQ-012 weight_cfg  input  NUM_CH*WEIGHT_BITS  channel i grant quota = field i + 1.
REQ-013 enable  input  1  0 = no new pops issued; in-flight transfer completes.
REQ-014 pop_signal  output  NUM_CH  registered one-hot pop.
REQ-015 push_signal  output  NUM_DEST  registered one-hot push.
REQ-016 data_out  output  LINE_SIZE  registered word accompanying push_signal.
REQ-017 dest_err  output  1  one-cycle pulse: popped word had dest >= NUM_DEST.
REQ-018 tx_count  output  16  count of completed pushes, wraps 0xFFFF->0.
REQ-019 idle  output  1  high when FSM in ARB and no pop pending.

Function
REQ-020 FSM states SHALL be ARB, POP, LATCH, PUSH; one transfer occupies exactly one pass.
REQ-021 Channel i eligible SHALL mean ~almost_empty_signal[i] and ~|almost_full_signal and enable.
REQ-022 In ARB with >=1 eligible channel: SHALL select grant, set pop_signal one-hot, go to POP.
REQ-023 In ARB with none eligible: SHALL stay in ARB, pop_signal = 0.
REQ-024 Grant: if channel ptr eligible and used < quota(ptr), SHALL grant ptr, used <= used+1.
REQ-025 Otherwise SHALL grant first eligible channel searching ptr+1, ptr+2, ... modulo NUM_CH; ptr <= that channel, used <= 1.
REQ-026 When a grant makes used == quota, SHALL set ptr <= (granted+1) mod NUM_CH, used <= 0.
REQ-027 POP: pop_signal high exactly one cycle; next state LATCH, pop_signal <= 0.
REQ-028 LATCH: SHALL sample data_in into data_out; if dest < NUM_DEST set push_signal[dest] <= 1, else dest_err <= 1; go to PUSH.
REQ-029 PUSH: push_signal/dest_err high exactly this cycle; cleared next edge; tx_count += 1 only on valid push; return to ARB.
REQ-030 Pop-to-push latency SHALL be 2 cycles; minimum spacing between pops 3 cycles.
REQ-031 almost_full/almost_empty changes after grant SHALL NOT abort the in-flight transfer.
REQ-032 weight_cfg SHALL be sampled only at grant time; changing it mid-burst takes effect at next grant.
REQ-033 ptr width SHALL be $clog2(NUM_CH); used width WEIGHT_BITS+1; no overflow possible.
REQ-034 At most one bit of pop_signal and of push_signal SHALL ever be high.

Reset
REQ-035 reset high SHALL immediately force: state ARB, pop_signal 0, push_signal 0, data_out 0, dest_err 0, tx_count 0, ptr 0, used 0, idle 1.
REQ-036 reset mid-transfer SHALL abandon the transfer; no push after release.
REQ-037 First grant after release SHALL be evaluated on the first clk edge with reset low.

Verification
REQ-038 All 4 sources non-empty, weights 0,0,0,0 -> pops ch0,1,2,3,0 one each, every 3 cycles.
REQ-039 Weights ch0=2 (quota 3), others 0 -> pop order 0,0,0,1,2,3,0,0,0.
REQ-040 ch1 only non-empty, data_in 12'h2A5 on cycle after pop -> push_signal[2]=1, data_out 12'h2A5 two cycles after pop, tx_count=1.
REQ-041 almost_full_signal[3]=1 with sources ready -> pop_signal stays 0, idle=1; deassert -> pop next edge.
REQ-042 NUM_DEST=3, word with dest=3 -> dest_err pulse 1 cycle, push_signal 0, tx_count unchanged.
REQ-043 reset asserted in LATCH -> all outputs 0 asynchronously, no push after release, ptr restarts at ch0.
